// File: rtl/reg_arb_pkg.sv
// Shared constants, index-width helper and enable-vector type for the register write arbiter.
package reg_arb_pkg;

    localparam int unsigned NUM_REQ_DEF  = 4;
    localparam int unsigned NUM_REGS_DEF = 4;
    localparam int unsigned DATA_W_DEF   = 8;

    // Width of an index into n items; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [NUM_REGS_DEF-1:0] reg_en_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection with rotating pointer.
// REG_WR_ARB_PRIO0_EN: requester 0 wins whenever valid and does not move the pointer.
module rr_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned N = NUM_REQ_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [N-1:0]          i_valid,
    input  logic                  i_hold,
    input  logic                  i_accept,
    output logic [N-1:0]          o_grant,
    output logic [idx_w(N)-1:0]   o_idx
);

    localparam int unsigned IW = idx_w(N);

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_ptr_nxt;
    logic [IW-1:0] w_inc;
    logic [N-1:0]  w_grant;
    logic [IW-1:0] w_idx;
    logic          w_found;
    int unsigned   w_j;

    // Scan from the pointer upward, wrapping; first valid requester wins.
    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        w_j     = 0;
        if (!i_hold) begin
`ifdef REG_WR_ARB_PRIO0_EN
            if (i_valid[0]) begin
                w_grant[0] = 1'b1;
                w_found    = 1'b1;
            end
`endif
            for (int unsigned k = 0; k < N; k++) begin
                w_j = (32'(r_ptr) + k) % N;
                if (!w_found && i_valid[w_j]) begin
                    w_grant[w_j] = 1'b1;
                    w_idx        = w_j[IW-1:0];
                    w_found      = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_inc     = (32'(w_idx) == N - 1) ? '0 : w_idx + 1'b1;
        w_ptr_nxt = r_ptr;
        if (i_accept) begin
`ifdef REG_WR_ARB_PRIO0_EN
            if (w_idx != '0) w_ptr_nxt = w_inc;
`else
            w_ptr_nxt = w_inc;
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

    assign o_grant = w_grant;
    assign o_idx   = w_idx;

endmodule

// File: rtl/reg_wr_arbiter.sv
// Arbitrates requester writes onto a registered one-hot enable plus shared data bus.
// REG_WR_ARB_PRIO0_EN (in rr_arbiter): requester 0 becomes fixed-priority.
module reg_wr_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = NUM_REQ_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = idx_w(NUM_REGS)
) (
    input  logic                        clk,
    input  logic                        rst_,
    input  logic                        hold,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REGS-1:0]         reg_en,
    output logic [DATA_W-1:0]           reg_data,
    output logic [idx_w(NUM_REQ)-1:0]   grant_id,
    output logic                        addr_err
);

    localparam int unsigned IW = idx_w(NUM_REQ);

    logic [NUM_REQ-1:0]  w_grant;
    logic [IW-1:0]       w_idx;
    logic                w_accept;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_data;
    logic [NUM_REGS-1:0] w_dec;
    logic                w_oob;

    logic [NUM_REGS-1:0] r_reg_en;
    logic [DATA_W-1:0]   r_reg_data;
    logic [IW-1:0]       r_grant_id;
    logic                r_addr_err;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .i_clk    (clk),
        .i_rst_n  (rst_),
        .i_valid  (req_valid),
        .i_hold   (hold),
        .i_accept (w_accept),
        .o_grant  (w_grant),
        .o_idx    (w_idx)
    );

    assign w_accept = |(req_valid & w_grant);

    // One-hot grant selects the winning address/data slice.
    always_comb begin
        w_addr = '0;
        w_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_addr = req_addr[i*ADDR_W +: ADDR_W];
                w_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_oob = (32'(w_addr) >= NUM_REGS);
        w_dec = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (32'(w_addr) == r) w_dec[r] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_reg_en   <= '0;
            r_reg_data <= '0;
            r_grant_id <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_reg_en   <= w_accept ? w_dec : '0;
            r_addr_err <= w_accept & w_oob;
            if (w_accept) begin
                r_reg_data <= w_data;
                r_grant_id <= w_idx;
            end
        end
    end

    assign req_ready = w_grant;
    assign reg_en    = r_reg_en;
    assign reg_data  = r_reg_data;
    assign grant_id  = r_grant_id;
    assign addr_err  = r_addr_err;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Randomised and directed self-checking bench for reg_wr_arbiter against a behavioural model.
module tb_reg_wr_arbiter;
    import reg_arb_pkg::*;

    localparam int NR = 4;
    localparam int NG = 4;
    localparam int DW = 8;
    localparam int AW = 2;

    logic             clk  = 1'b0;
    logic             rst_ = 1'b1;
    logic             hold = 1'b0;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*AW-1:0] req_addr  = '0;
    logic [NR*DW-1:0] req_data  = '0;
    logic [NR-1:0]    req_ready;
    reg_en_t          reg_en;
    logic [DW-1:0]    reg_data;
    logic [1:0]       grant_id;
    logic             addr_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected registered outputs and pointer
    int        m_ptr  = 0;
    reg_en_t   m_en   = '0;
    logic [7:0] m_data = '0;
    int        m_gid  = 0;
    logic      m_err  = 1'b0;

    logic       pend  [NR];
    logic [1:0] paddr [NR];
    logic [7:0] pdata [NR];

    reg_wr_arbiter dut (
        .clk       (clk),
        .rst_      (rst_),
        .hold      (hold),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .reg_en    (reg_en),
        .reg_data  (reg_data),
        .grant_id  (grant_id),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner by the rules: hold blocks, optional requester-0 priority, else scan from ptr.
    function automatic int model_pick(input logic [NR-1:0] v, input int p, input logic h);
        if (h) return -1;
`ifdef REG_WR_ARB_PRIO0_EN
        if (v[0]) return 0;
`endif
        for (int k = 0; k < NR; k++) begin
            if (v[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic v, input logic [1:0] a, input logic [7:0] d);
        req_valid[i]          = v;
        req_addr[i*AW +: AW]  = a;
        req_data[i*DW +: DW]  = d;
    endtask

    // Called just after a rising edge with inputs applied; checks grant, then outputs after edge.
    task automatic run_cycle(output int g);
        int a;
        #2;
        g = model_pick(req_valid, m_ptr, hold);
        check("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
        if (g >= 0) begin
            a      = int'(req_addr[g*AW +: AW]);
            m_data = req_data[g*DW +: DW];
            m_gid  = g;
            m_en   = (a < NG) ? reg_en_t'(1 << a) : '0;
            m_err  = (a >= NG);
`ifdef REG_WR_ARB_PRIO0_EN
            if (g != 0) m_ptr = (g + 1) % NR;
`else
            m_ptr = (g + 1) % NR;
`endif
        end else begin
            m_en  = '0;
            m_err = 1'b0;
        end
        @(posedge clk);
        #1;
        check("reg_en",   32'(reg_en),   32'(m_en));
        check("reg_data", 32'(reg_data), 32'(m_data));
        check("grant_id", 32'(grant_id), 32'(m_gid));
        check("addr_err", 32'(addr_err), 32'(m_err));
    endtask

    task automatic do_reset();
        req_valid = '0;
        hold      = 1'b0;
        #1 rst_ = 1'b0;
        #1;
        check("rst_reg_en",   32'(reg_en),   32'h0);
        check("rst_reg_data", 32'(reg_data), 32'h0);
        check("rst_grant_id", 32'(grant_id), 32'h0);
        check("rst_addr_err", 32'(addr_err), 32'h0);
        m_ptr = 0; m_en = '0; m_data = '0; m_gid = 0; m_err = 1'b0;
        @(negedge clk);
        rst_ = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int g;
        do_reset();

        repeat (10) begin
            run_cycle(g);
            check("idle_reg_data", 32'(reg_data), 32'h00);
        end

        // Single write from requester 1
        set_req(1, 1'b1, 2'd2, 8'hA5);
        #1 check("single_ready", 32'(req_ready), 32'b0010);
        run_cycle(g);
        set_req(1, 1'b0, 2'd0, 8'h00);
        check("single_en",   32'(reg_en),   32'b0100);
        check("single_data", 32'(reg_data), 32'hA5);
        run_cycle(g);
        check("single_pulse", 32'(reg_en), 32'b0000);

        // All valid: fairness order and back-to-back data
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 2'(i), 8'(8'h10 + i));
        for (int c = 0; c < 9; c++) begin
`ifndef REG_WR_ARB_PRIO0_EN
            #1 check("rr_ready", 32'(req_ready), 32'd1 << (c % NR));
`endif
            run_cycle(g);
`ifndef REG_WR_ARB_PRIO0_EN
            check("rr_data", 32'(reg_data), 32'(8'h10 + (c % NR)));
`endif
        end

        // Hold: in-flight write drains, then nothing until release
        hold = 1'b1;
`ifndef REG_WR_ARB_PRIO0_EN
        check("hold_drain_en", 32'(reg_en), 32'b0001);
`endif
        repeat (3) begin
            #1 check("hold_ready", 32'(req_ready), 32'h0);
            run_cycle(g);
        end
        hold = 1'b0;
`ifndef REG_WR_ARB_PRIO0_EN
        #1 check("hold_resume", 32'(req_ready), 32'b0010);
`endif
        repeat (4) run_cycle(g);

        // Reset while a write sits in the output stage
        do_reset();
        set_req(2, 1'b1, 2'd1, 8'h3C);
        run_cycle(g);
        check("midrst_pre_en", 32'(reg_en), 32'b0010);
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 2'(i), 8'(8'h20 + i));
        #1 check("midrst_first", 32'(req_ready), 32'b0001);
        run_cycle(g);

`ifdef REG_WR_ARB_PRIO0_EN
        do_reset();
        set_req(0, 1'b1, 2'd0, 8'h55);
        set_req(3, 1'b1, 2'd3, 8'h66);
        repeat (3) begin
            #1 check("prio_req0", 32'(req_ready), 32'b0001);
            run_cycle(g);
        end
        set_req(0, 1'b0, 2'd0, 8'h00);
        #1 check("prio_req3", 32'(req_ready), 32'b1000);
        run_cycle(g);
`endif

        // Random traffic: requesters hold their request until granted
        do_reset();
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
        repeat (400) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pend[i]  = 1'b1;
                    paddr[i] = 2'($urandom_range(0, 3));
                    pdata[i] = 8'($urandom);
                end
                set_req(i, pend[i], paddr[i], pdata[i]);
            end
            hold = ($urandom_range(0, 7) == 0);
            run_cycle(g);
            if (g >= 0) pend[g] = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_wr_arbiter.md
Name: reg_wr_arbiter

Overview:
- Shares the write side of a bank of 8-bit enable-gated registers between several requesters (decode, ALU writeback, load unit, debug).
- Accepts one write per cycle through a valid/ready handshake and selects the winner round-robin.
- Drives a registered one-hot enable vector plus a shared data bus into the register bank.
- Sits between the CPU control/datapath producers and the register instances.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- NUM_REGS, 4, number of target registers (2..16).
- DATA_W, 8, data width.
- ADDR_W, $clog2(NUM_REGS), register address width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst_  in  1  asynchronous active-low reset.
- hold  in  1  freeze: no grants while high.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  packed data; requester i at [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot (or zero) grant, combinational.
- reg_en  out  NUM_REGS  one-hot write enable to the register bank, registered.
- reg_data  out  DATA_W  write data to the register bank, registered.
- grant_id  out  $clog2(NUM_REQ)  index of the last accepted requester, registered.
- addr_err  out  1  one-cycle pulse: the accepted request had addr >= NUM_REGS.

Behaviour:
- Reset is asynchronous and active-low on rst_, clocked on clk.
- Reset values: reg_en=0, reg_data=0, grant_id=0, addr_err=0, round-robin pointer ptr=0.
- Grant (combinational): search req_valid from index ptr upward, wrapping modulo NUM_REQ. The first valid requester gets req_ready=1; all others get 0.
- hold=1 forces req_ready=0.
- Handshake: a request completes in the cycle req_valid[i] & req_ready[i]. At most one completes per cycle.
- Requesters hold valid, addr and data stable until ready; the arbiter never drops an asserted request.
- Latency: for a handshake in cycle N, reg_en/reg_data/grant_id are valid in cycle N+1, and the register captures on the N+2 rising edge.
- reg_en is asserted for exactly one cycle per accepted write.
- Pointer: after a handshake with requester g, ptr <= (g+1) mod NUM_REQ. With no handshake, ptr holds.
- No handshake in cycle N (no valid, or hold=1): reg_en=0 in N+1; reg_data and grant_id hold their previous values.
- Address out of range (addr >= NUM_REGS, only possible when NUM_REGS is not a power of two):
  - the handshake still completes and ptr advances;
  - reg_en=0 in N+1;
  - addr_err=1 in N+1;
  - reg_data and grant_id update as normal.
- Back-to-back: a new grant is allowed every cycle. No bubble between consecutive writes, including two writes to the same register (the later one wins).
- Single requester continuously valid: granted every cycle.
- All requesters valid: grant order ptr, ptr+1, ... with no starvation; worst-case wait is NUM_REQ-1 cycles.
- Reset asserted mid-operation: the output stage clears immediately, so any write accepted in the previous cycle is discarded (reg_en=0), and ptr returns to 0.
- hold asserted while a write sits in the output stage: that write still issues; only new grants stop.

Optional Feature:
- Macro: REG_WR_ARB_PRIO0_EN.
- Defined: requester 0 is fixed-priority. Whenever req_valid[0]=1 and hold=0, requester 0 gets ready regardless of ptr, and ptr does not advance on requester-0 grants. Other requesters arbitrate round-robin only when requester 0 is idle.
- Undefined: pure round-robin as above, with requester 0 treated like any other.

Decomposition:
- Package reg_arb_pkg holds:
  - default constants NUM_REQ_DEF=4, NUM_REGS_DEF=4, DATA_W_DEF=8;
  - a function for index-width computation;
  - the typedef for the one-hot enable vector.
- Sub-module rr_arbiter (parameter N) contains the combinational rotate/priority-select grant logic and the ptr register. It takes valid, hold and an accept strobe, and returns the one-hot grant and the encoded index.
- reg_wr_arbiter adds the data/address muxing, the decoder and the registered output stage.

Test Plan:
- Reset then idle: rst_=0→1, no valid → reg_en=0, reg_data=0x00, grant_id=0 for 10 cycles.
- Single write: req1 valid, addr=2, data=0xA5 in cycle N → req_ready=4'b0010 in N; reg_en=4'b0100 and reg_data=0xA5 in N+1; pulse lasts exactly one cycle.
- Round-robin fairness: all 4 valid for 8 cycles with data 0x10+i → grant order 0,1,2,3,0,1,2,3; reg_data sequence 0x10,0x11,0x12,0x13,... with no bubble.
- Hold: all valid, hold=1 for 3 cycles → req_ready=0 and reg_en=0 (after draining one in-flight write); on release, grant resumes at the held ptr.
- Reset mid-write: handshake req2 (addr=1, 0x3C) in N, rst_=0 during N+1 → reg_en=0 immediately; after release, first grant goes to requester 0.
- REG_WR_ARB_PRIO0_EN defined: req0 valid continuously, req3 valid → only req0 granted. Drop req0 → req3 granted the next cycle.
